// File: rtl/fft_dif_stage.sv
// rtl/fft_dif_stage.sv - radix-2 DIF first FFT stage: N/2 parallel butterflies, twiddle multiply, 2-stage valid/ready pipeline
// Optional feature macro: FFT_STAGE_SAT_EN (saturating output narrowing plus sticky sat_flag output).
module fft_dif_stage #(
    parameter int N_POINTS = 8,
    parameter int IN_W     = 12,
    parameter int TW_W     = 12,
    parameter int CNT_W    = 16
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_scale,
    input  logic [N_POINTS*IN_W-1:0] in_re,
    input  logic [N_POINTS*IN_W-1:0] in_im,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N_POINTS*IN_W-1:0] out_re,
    output logic [N_POINTS*IN_W-1:0] out_im,
`ifdef FFT_STAGE_SAT_EN
    output logic                     sat_flag,
`endif
    output logic [CNT_W-1:0]         frame_cnt
);

    localparam int HALF    = N_POINTS / 2;
    localparam int TW_FRAC = TW_W - 2;
    localparam int A_W     = IN_W + 1;
    localparam int P_W     = IN_W + TW_W + 2;
    localparam int V_W     = N_POINTS * IN_W;

    // sin(m*pi/8) for m = 0..4 in Q30; every legal frame size uses angles on this 16th-of-a-turn grid.
    function automatic longint sin_q30(input int m);
        case (m)
            0:       sin_q30 = 64'sd0;
            1:       sin_q30 = 64'sd410903207;
            2:       sin_q30 = 64'sd759250125;
            3:       sin_q30 = 64'sd992008094;
            default: sin_q30 = 64'sd1073741824;
        endcase
    endfunction

    // Twiddle W^k = cos(2*pi*k/N) - j*sin(2*pi*k/N), rounded to nearest in Q2.TW_FRAC.
    function automatic logic [TW_W-1:0] tw_coef(input int k, input logic want_im);
        int     m;
        longint mag;
        longint r;
        logic   neg;
        m = (k * 16) / N_POINTS;
        if (!want_im) begin
            if (m <= 4) begin
                mag = sin_q30(4 - m);
                neg = 1'b0;
            end else begin
                mag = sin_q30(m - 4);
                neg = 1'b1;
            end
        end else begin
            // Angles lie in [0, pi), so sin is non-negative and the imaginary part is its negation.
            mag = (m <= 4) ? sin_q30(m) : sin_q30(8 - m);
            neg = 1'b1;
        end
        r = (mag + (longint'(1) <<< (29 - TW_FRAC))) >>> (30 - TW_FRAC);
        if (neg) begin
            r = -r;
        end
        tw_coef = r[TW_W-1:0];
    endfunction

    // Arithmetic right shift with the operand forced signed inside the function.
    function automatic logic [P_W-1:0] asr(input logic signed [P_W-1:0] v, input int sh);
        asr = v >>> sh;
    endfunction

`ifdef FFT_STAGE_SAT_EN
    // A lane overflows when the bits above the IN_W-bit sign position disagree.
    function automatic logic lane_ovf(input logic [P_W-1:0] v);
        lane_ovf = !((&v[P_W-1:IN_W-1]) || !(|v[P_W-1:IN_W-1]));
    endfunction
`endif

    // Final narrowing of a lane to IN_W bits: clamp when saturation is built in, otherwise wrap.
    function automatic logic [IN_W-1:0] fit_lane(input logic [P_W-1:0] v);
`ifdef FFT_STAGE_SAT_EN
        if (lane_ovf(v)) begin
            fit_lane = v[P_W-1] ? {1'b1, {(IN_W-1){1'b0}}} : {1'b0, {(IN_W-1){1'b1}}};
        end else begin
            fit_lane = v[IN_W-1:0];
        end
`else
        fit_lane = v[IN_W-1:0];
`endif
    endfunction

    // Handshake: stage 2 may load whenever it is empty or draining; stage 1 whenever it can pass forward.
    logic s1_valid_q;
    logic s1_scale_q;
    logic out_valid_q;
    logic s2_load;
    logic accept;
    logic xfer;

    assign s2_load  = !out_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_load;
    assign accept   = in_valid && in_ready;
    assign xfer     = out_valid_q && out_ready;

    // Stage 1 state: butterfly sum a and difference b per pair, IN_W+1 bits so neither can overflow.
    logic [HALF-1:0][A_W-1:0] a_re_d, a_im_d, b_re_d, b_im_d;
    logic [HALF-1:0][A_W-1:0] a_re_q, a_im_q, b_re_q, b_im_q;

    for (genvar k = 0; k < HALF; k++) begin : g_bfly
        logic [A_W-1:0] u_re, u_im, l_re, l_im;
        assign u_re = {in_re[k*IN_W+IN_W-1], in_re[k*IN_W +: IN_W]};
        assign u_im = {in_im[k*IN_W+IN_W-1], in_im[k*IN_W +: IN_W]};
        assign l_re = {in_re[(k+HALF)*IN_W+IN_W-1], in_re[(k+HALF)*IN_W +: IN_W]};
        assign l_im = {in_im[(k+HALF)*IN_W+IN_W-1], in_im[(k+HALF)*IN_W +: IN_W]};
        assign a_re_d[k] = u_re + l_re;
        assign a_im_d[k] = u_im + l_im;
        assign b_re_d[k] = u_re - l_re;
        assign b_im_d[k] = u_im - l_im;
    end

    // Stage 1 occupancy: refilled (or emptied) whenever the stage is allowed to move.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            s1_valid_q <= 1'b0;
        end else if (in_ready) begin
            s1_valid_q <= in_valid;
        end
    end

    // Stage 1 data and scale bit: captured only on an accepted frame.
    always_ff @(posedge CLK) begin
        if (accept) begin
            a_re_q     <= a_re_d;
            a_im_q     <= a_im_d;
            b_re_q     <= b_re_d;
            b_im_q     <= b_im_d;
            s1_scale_q <= in_scale;
        end
    end

    // Stage 2 combinational datapath: scale upper branch, twiddle-multiply and scale lower branch.
    logic [V_W-1:0]    out_re_d, out_im_d;
    logic [V_W-1:0]    out_re_q, out_im_q;
`ifdef FFT_STAGE_SAT_EN
    logic [HALF-1:0]   lane_sat;
    logic              frame_sat_d;
    logic              frame_sat_q;
    logic              sat_flag_q;
`endif

    for (genvar k = 0; k < HALF; k++) begin : g_s2
        localparam logic [TW_W-1:0] WR = tw_coef(k, 1'b0);
        localparam logic [TW_W-1:0] WI = tw_coef(k, 1'b1);
        logic [P_W-1:0] ar_x, ai_x, br_x, bi_x, wr_x, wi_x;
        logic [P_W-1:0] pr, pi, ur, ui, lr, li;

        assign ar_x = {{(P_W-A_W){a_re_q[k][A_W-1]}}, a_re_q[k]};
        assign ai_x = {{(P_W-A_W){a_im_q[k][A_W-1]}}, a_im_q[k]};
        assign br_x = {{(P_W-A_W){b_re_q[k][A_W-1]}}, b_re_q[k]};
        assign bi_x = {{(P_W-A_W){b_im_q[k][A_W-1]}}, b_im_q[k]};
        assign wr_x = {{(P_W-TW_W){WR[TW_W-1]}}, WR};
        assign wi_x = {{(P_W-TW_W){WI[TW_W-1]}}, WI};

        // Sign-extended operands make the modulo-2^P_W product equal to the signed product.
        assign pr = br_x * wr_x - bi_x * wi_x;
        assign pi = br_x * wi_x + bi_x * wr_x;

        assign ur = s1_scale_q ? asr(ar_x, 1) : ar_x;
        assign ui = s1_scale_q ? asr(ai_x, 1) : ai_x;
        assign lr = s1_scale_q ? asr(pr, TW_FRAC + 1) : asr(pr, TW_FRAC);
        assign li = s1_scale_q ? asr(pi, TW_FRAC + 1) : asr(pi, TW_FRAC);

        assign out_re_d[k*IN_W +: IN_W]        = fit_lane(ur);
        assign out_im_d[k*IN_W +: IN_W]        = fit_lane(ui);
        assign out_re_d[(k+HALF)*IN_W +: IN_W] = fit_lane(lr);
        assign out_im_d[(k+HALF)*IN_W +: IN_W] = fit_lane(li);
`ifdef FFT_STAGE_SAT_EN
        assign lane_sat[k] = lane_ovf(ur) | lane_ovf(ui) | lane_ovf(lr) | lane_ovf(li);
`endif
    end

`ifdef FFT_STAGE_SAT_EN
    assign frame_sat_d = |lane_sat;
`endif

    // Stage 2 output register: holds the frame stable while downstream stalls.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            out_valid_q <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
`ifdef FFT_STAGE_SAT_EN
            frame_sat_q <= 1'b0;
`endif
        end else if (s2_load) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_re_q    <= out_re_d;
                out_im_q    <= out_im_d;
`ifdef FFT_STAGE_SAT_EN
                frame_sat_q <= frame_sat_d;
`endif
            end
        end
    end

    // Frame counter: one count per output transfer, free-running wrap.
    logic [CNT_W-1:0] frame_cnt_q;
    logic [CNT_W-1:0] frame_cnt_d;
    assign frame_cnt_d = frame_cnt_q + CNT_W'(1);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            frame_cnt_q <= '0;
        end else if (xfer) begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

`ifdef FFT_STAGE_SAT_EN
    // Sticky saturation flag: only a frame that actually leaves the block can set it.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sat_flag_q <= 1'b0;
        end else if (xfer && frame_sat_q) begin
            sat_flag_q <= 1'b1;
        end
    end

    assign sat_flag = sat_flag_q;
`endif

    assign out_valid = out_valid_q;
    assign out_re    = out_re_q;
    assign out_im    = out_im_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_fft_dif_stage.sv
// tb/tb_fft_dif_stage.sv - self-checking bench for fft_dif_stage with a behavioural FFT-stage model
module tb_fft_dif_stage;

    localparam int N  = 8;
    localparam int W  = 12;
    localparam int CW = 16;
    localparam int H  = N / 2;
    localparam int VW = N * W;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          in_valid;
    logic          in_ready;
    logic          in_scale;
    logic [VW-1:0] in_re;
    logic [VW-1:0] in_im;
    logic          out_valid;
    logic          out_ready;
    logic [VW-1:0] out_re;
    logic [VW-1:0] out_im;
    logic [CW-1:0] frame_cnt;
`ifdef FFT_STAGE_SAT_EN
    logic          sat_flag;
`endif

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    fft_dif_stage #(.N_POINTS(N), .IN_W(W), .TW_W(12), .CNT_W(CW)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_scale  (in_scale),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
`ifdef FFT_STAGE_SAT_EN
        .sat_flag  (sat_flag),
`endif
        .frame_cnt (frame_cnt)
    );

    // Twiddle from trigonometry, rounded to nearest in Q2.10.
    function automatic int tw(input int k, input bit want_im);
        real ang, v;
        ang = 2.0 * 3.141592653589793 * real'(k) / real'(N);
        v = want_im ? -$sin(ang) * 1024.0 : $cos(ang) * 1024.0;
        return (v >= 0.0) ? int'($floor(v + 0.5)) : -int'($floor(-v + 0.5));
    endfunction

    function automatic logic [W-1:0] fit(input int v);
`ifdef FFT_STAGE_SAT_EN
        if (v > 2047) v = 2047;
        if (v < -2048) v = -2048;
`endif
        return v[W-1:0];
    endfunction

    // Reference: whole-frame DIF butterfly with integer arithmetic.
    task automatic model(input logic [VW-1:0] xr, input logic [VW-1:0] xi, input bit s,
                         output logic [VW-1:0] yr, output logic [VW-1:0] yi, output bit sat);
        int ur, ui, lr, li, ar, ai, br, bi, wr, wi;
        int v[4];
        sat = 0;
        yr  = '0;
        yi  = '0;
        for (int k = 0; k < H; k++) begin
            ur = int'($signed(xr[k*W +: W]));
            ui = int'($signed(xi[k*W +: W]));
            lr = int'($signed(xr[(k+H)*W +: W]));
            li = int'($signed(xi[(k+H)*W +: W]));
            ar = ur + lr; ai = ui + li;
            br = ur - lr; bi = ui - li;
            wr = tw(k, 1'b0); wi = tw(k, 1'b1);
            v[0] = s ? (ar >>> 1) : ar;
            v[1] = s ? (ai >>> 1) : ai;
            v[2] = (br * wr - bi * wi) >>> (10 + int'(s));
            v[3] = (br * wi + bi * wr) >>> (10 + int'(s));
            for (int j = 0; j < 4; j++) begin
                if (v[j] > 2047 || v[j] < -2048) sat = 1;
            end
            yr[k*W +: W]     = fit(v[0]);
            yi[k*W +: W]     = fit(v[1]);
            yr[(k+H)*W +: W] = fit(v[2]);
            yi[(k+H)*W +: W] = fit(v[3]);
        end
    endtask

    function automatic logic [VW-1:0] rand_frame();
        logic [VW-1:0] f;
        for (int l = 0; l < N; l++) begin
            f[l*W +: W] = 12'($urandom_range(0, 4095));
        end
        return f;
    endfunction

    task automatic do_reset();
        @(posedge CLK); #1;
        RESET = 1'b1; in_valid = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge CLK);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (frame_cnt !== '0) begin errors++; $display("FAIL reset_frame_cnt got %0d want 0", frame_cnt); end
        checks++; if (out_re !== '0 || out_im !== '0) begin errors++; $display("FAIL reset_out_data got %h/%h want 0", out_re, out_im); end
`ifdef FFT_STAGE_SAT_EN
        checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL reset_sat_flag got %b want 0", sat_flag); end
`endif
    endtask

    task automatic test_directed();
        logic [VW-1:0] xr, xi, er, ei, mr, mi;
        bit sc, ms;
        for (int c = 0; c < 3; c++) begin
            xr = '0; xi = '0; er = '0; ei = '0;
            case (c)
                0: begin
                    sc = 1; xr[0*W +: W] = 12'd100; xr[4*W +: W] = 12'd50;
                    er[0*W +: W] = 12'd75; er[4*W +: W] = 12'd25;
                end
                1: begin
                    sc = 1; xr[1*W +: W] = 12'd200;
                    er[1*W +: W] = 12'd100; er[5*W +: W] = 12'd70; ei[5*W +: W] = -12'sd71;
                end
                default: begin
                    sc = 0; xr[2*W +: W] = 12'd64;
                    er[2*W +: W] = 12'd64; ei[6*W +: W] = -12'sd64;
                end
            endcase
            model(xr, xi, sc, mr, mi, ms);
            @(posedge CLK); #1;
            out_ready = 1'b1; in_valid = 1'b1; in_re = xr; in_im = xi; in_scale = sc;
            @(negedge CLK);
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL dir%0d_in_ready got %b want 1", c, in_ready); end
            @(posedge CLK); #1;
            in_valid = 1'b0; in_re = rand_frame(); in_im = rand_frame();
            @(negedge CLK);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dir%0d_latency_early got %b want 0", c, out_valid); end
            @(negedge CLK);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL dir%0d_latency got %b want 1", c, out_valid); end
            checks++; if (out_re !== er || out_im !== ei) begin errors++; $display("FAIL dir%0d_const got %h/%h want %h/%h", c, out_re, out_im, er, ei); end
            checks++; if (out_re !== mr || out_im !== mi) begin errors++; $display("FAIL dir%0d_model got %h/%h want %h/%h", c, out_re, out_im, mr, mi); end
        end
    endtask

    task automatic test_back_to_back();
        logic [VW-1:0] fr[3], fi[3], er[3], ei[3], hr, hi;
        bit fs[3], ms;
        int acc, got;
        bit held;
        do_reset();
        acc = 0; got = 0; held = 0;
        for (int i = 0; i < 3; i++) begin
            fr[i] = rand_frame(); fi[i] = rand_frame(); fs[i] = 1'($urandom_range(0, 1));
            model(fr[i], fi[i], fs[i], er[i], ei[i], ms);
        end
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(posedge CLK); #1;
            out_ready = 1'b0;
            in_valid = (acc < 3);
            if (acc < 3) begin in_re = fr[acc]; in_im = fi[acc]; in_scale = fs[acc]; end
            @(negedge CLK);
            if (out_valid === 1'b1 && held) begin
                checks++; if (out_re !== hr || out_im !== hi) begin errors++; $display("FAIL b2b_hold got %h want %h", out_re, hr); end
            end
            if (out_valid === 1'b1 && !held) begin held = 1; hr = out_re; hi = out_im; end
            if (in_valid && in_ready) acc++;
        end
        checks++; if (acc != 2) begin errors++; $display("FAIL b2b_accepted got %0d want 2", acc); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall_in_ready got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b1 || out_re !== er[0] || out_im !== ei[0]) begin errors++; $display("FAIL b2b_held_frame got %b %h want 1 %h", out_valid, out_re, er[0]); end
        for (int cyc = 0; cyc < 20 && got < 3; cyc++) begin
            @(posedge CLK); #1;
            out_ready = 1'b1;
            in_valid = (acc < 3);
            if (acc < 3) begin in_re = fr[acc]; in_im = fi[acc]; in_scale = fs[acc]; end
            @(negedge CLK);
            if (out_valid === 1'b1) begin
                checks++; if (out_re !== er[got] || out_im !== ei[got]) begin errors++; $display("FAIL b2b_order%0d got %h want %h", got, out_re, er[got]); end
                got++;
            end
            if (in_valid && in_ready) acc++;
        end
        @(posedge CLK); #1;
        in_valid = 1'b0;
        @(negedge CLK);
        checks++; if (got != 3) begin errors++; $display("FAIL b2b_count got %0d want 3", got); end
        checks++; if (frame_cnt !== 16'd3) begin errors++; $display("FAIL b2b_frame_cnt got %0d want 3", frame_cnt); end
    endtask

    task automatic test_overflow();
        logic [VW-1:0] xr, xi, mr, mi;
        logic [W-1:0] want0;
        bit ms;
        xr = '0; xi = '0;
        xr[0*W +: W] = 12'd2047; xr[4*W +: W] = 12'd1;
`ifdef FFT_STAGE_SAT_EN
        want0 = 12'h7FF;
`else
        want0 = 12'h800;
`endif
        model(xr, xi, 1'b0, mr, mi, ms);
        @(posedge CLK); #1;
        out_ready = 1'b1; in_valid = 1'b1; in_re = xr; in_im = xi; in_scale = 1'b0;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        checks++; if (out_valid !== 1'b1 || out_re[0*W +: W] !== want0) begin errors++; $display("FAIL ovf_lane0 got %b %h want 1 %h", out_valid, out_re[0*W +: W], want0); end
        checks++; if (out_re !== mr || out_im !== mi) begin errors++; $display("FAIL ovf_model got %h want %h", out_re, mr); end
`ifdef FFT_STAGE_SAT_EN
        @(negedge CLK);
        checks++; if (sat_flag !== 1'b1) begin errors++; $display("FAIL ovf_sat_set got %b want 1", sat_flag); end
        @(posedge CLK); #1;
        in_valid = 1'b1; in_re = '0; in_im = '0;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) @(negedge CLK);
        checks++; if (sat_flag !== 1'b1) begin errors++; $display("FAIL ovf_sat_sticky got %b want 1", sat_flag); end
`endif
    endtask

    task automatic test_reset_inflight();
        int seen;
        seen = 0;
        for (int i = 0; i < 2; i++) begin
            @(posedge CLK); #1;
            out_ready = 1'b0; in_valid = 1'b1; in_re = rand_frame(); in_im = rand_frame(); in_scale = 1'b1;
        end
        @(posedge CLK); #1;
        in_valid = 1'b0; RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0; out_ready = 1'b1;
        @(negedge CLK);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_flight_out_valid got %b want 0", out_valid); end
        checks++; if (frame_cnt !== '0) begin errors++; $display("FAIL rst_flight_frame_cnt got %0d want 0", frame_cnt); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_flight_in_ready got %b want 1", in_ready); end
`ifdef FFT_STAGE_SAT_EN
        checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL rst_flight_sat_flag got %b want 0", sat_flag); end
`endif
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (out_valid === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL rst_flight_stale got %0d frames want 0", seen); end
    endtask

    task automatic test_random();
        logic [VW-1:0] qr[$], qi[$];
        bit qs[$];
        logic [VW-1:0] mr, mi, hr, hi;
        bit ms, acc_last, prev_stall, any_sat, exp_rdy;
        int xfers;
        do_reset();
        acc_last = 0; prev_stall = 0; any_sat = 0; xfers = 0;
        for (int cyc = 0; cyc < 420; cyc++) begin
            @(posedge CLK); #1;
            if (cyc >= 400) begin
                in_valid = 1'b0; out_ready = 1'b1;
            end else begin
                if (!in_valid || acc_last) begin
                    in_valid = ($urandom_range(0, 3) != 0);
                    in_re = rand_frame(); in_im = rand_frame(); in_scale = 1'($urandom_range(0, 1));
                end
                out_ready = ($urandom_range(0, 3) != 0);
            end
            @(negedge CLK);
            exp_rdy = (qr.size() < 2) || out_ready;
            checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL rnd_in_ready cyc %0d got %b want %b", cyc, in_ready, exp_rdy); end
            if (prev_stall) begin
                checks++; if (out_valid !== 1'b1 || out_re !== hr || out_im !== hi) begin errors++; $display("FAIL rnd_hold cyc %0d got %b %h want 1 %h", cyc, out_valid, out_re, hr); end
            end
            if (out_valid === 1'b1 && out_ready) begin
                checks++;
                if (qr.size() == 0) begin
                    errors++; $display("FAIL rnd_spurious cyc %0d got frame want none", cyc);
                end else begin
                    if (out_re !== qr[0] || out_im !== qi[0]) begin errors++; $display("FAIL rnd_data cyc %0d got %h/%h want %h/%h", cyc, out_re, out_im, qr[0], qi[0]); end
                    any_sat = any_sat | qs[0];
                    void'(qr.pop_front()); void'(qi.pop_front()); void'(qs.pop_front());
                    xfers++;
                end
            end
            prev_stall = (out_valid === 1'b1) && !out_ready;
            hr = out_re; hi = out_im;
            acc_last = in_valid && (in_ready === 1'b1);
            if (acc_last) begin
                model(in_re, in_im, in_scale, mr, mi, ms);
                qr.push_back(mr); qi.push_back(mi); qs.push_back(ms);
            end
        end
        checks++; if (qr.size() != 0) begin errors++; $display("FAIL rnd_drain got %0d left want 0", qr.size()); end
        checks++; if (frame_cnt !== 16'(xfers)) begin errors++; $display("FAIL rnd_frame_cnt got %0d want %0d", frame_cnt, xfers); end
`ifdef FFT_STAGE_SAT_EN
        checks++; if (sat_flag !== any_sat) begin errors++; $display("FAIL rnd_sat_flag got %b want %b", sat_flag, any_sat); end
`endif
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b0; in_valid = 1'b0; in_scale = 1'b0; out_ready = 1'b0;
        in_re = '0; in_im = '0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_overflow();
        test_reset_inflight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
